// File: rtl/regfile_operand_fetch_stage_if.sv
// Shared types and the issue/writeback/operand bundle of the operand fetch stage.

package regfile_operand_fetch_pkg;
  localparam int unsigned THREADS_PER_CORE = 4;
  localparam int unsigned VECTOR_LANES = 16;
  localparam int unsigned THREAD_IDX_WIDTH = $clog2(THREADS_PER_CORE);

  typedef logic [THREAD_IDX_WIDTH-1:0] thread_idx_t;
  typedef logic [3:0] subcycle_t;
  typedef logic [4:0] reg_idx_t;
  typedef logic [31:0] scalar_t;
  typedef scalar_t [VECTOR_LANES-1:0] vector_t;
  typedef logic [VECTOR_LANES-1:0] vector_lane_mask_t;

  typedef enum logic [1:0] {Op2Scalar2, Op2Vector2, Op2Immediate} op2_src_t;
  typedef enum logic [1:0] {MaskScalar1, MaskScalar2, MaskAllOnes} mask_src_t;

  typedef struct packed {
    reg_idx_t  scalar_sel1;
    reg_idx_t  scalar_sel2;
    reg_idx_t  vector_sel1;
    reg_idx_t  vector_sel2;
    logic      op1_is_vector;
    op2_src_t  op2_src;
    mask_src_t mask_src;
    scalar_t   immediate_value;
  } decoded_instruction_t;
endpackage

interface regfile_operand_fetch_stage_if import regfile_operand_fetch_pkg::*; ();
  // Issue from thread select
  logic                 ts_instruction_valid;
  decoded_instruction_t ts_instruction;
  thread_idx_t          ts_thread_idx;
  subcycle_t            ts_subcycle;
  // Rollback and register writes from writeback
  logic                 wb_rollback_en;
  thread_idx_t          wb_rollback_thread_idx;
  logic                 wb_writeback_en;
  thread_idx_t          wb_writeback_thread_idx;
  logic                 wb_writeback_is_vector;
  reg_idx_t             wb_writeback_reg;
  vector_t              wb_writeback_value;
  vector_lane_mask_t    wb_writeback_mask;
  // Operands towards execute
  logic                 of_instruction_valid;
  decoded_instruction_t of_instruction;
  thread_idx_t          of_thread_idx;
  subcycle_t            of_subcycle;
  vector_t              of_operand1;
  vector_t              of_operand2;
  vector_lane_mask_t    of_mask_value;

  modport master (
    output ts_instruction_valid, ts_instruction, ts_thread_idx, ts_subcycle,
    output wb_rollback_en, wb_rollback_thread_idx,
    output wb_writeback_en, wb_writeback_thread_idx, wb_writeback_is_vector,
    output wb_writeback_reg, wb_writeback_value, wb_writeback_mask,
    input  of_instruction_valid, of_instruction, of_thread_idx, of_subcycle,
    input  of_operand1, of_operand2, of_mask_value
  );

  modport slave (
    input  ts_instruction_valid, ts_instruction, ts_thread_idx, ts_subcycle,
    input  wb_rollback_en, wb_rollback_thread_idx,
    input  wb_writeback_en, wb_writeback_thread_idx, wb_writeback_is_vector,
    input  wb_writeback_reg, wb_writeback_value, wb_writeback_mask,
    output of_instruction_valid, of_instruction, of_thread_idx, of_subcycle,
    output of_operand1, of_operand2, of_mask_value
  );
endinterface

// File: rtl/regfile_operand_fetch_stage.sv
// Operand fetch: per-thread scalar/vector register files, write bypass, operand
// muxing and rollback squash, with one cycle of latency.

module regfile_operand_fetch_stage import regfile_operand_fetch_pkg::*; #(
  parameter int unsigned THREADS  = THREADS_PER_CORE,
  parameter int unsigned LANES    = VECTOR_LANES,
  parameter int unsigned NUM_REGS = 32
) (
  input logic                         clk,
  input logic                         reset,
  regfile_operand_fetch_stage_if.slave bus
);

  localparam int unsigned DEPTH = THREADS * NUM_REGS;
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

  // Flat address is {thread, register}; each thread owns a contiguous bank
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  scalar_t scalar_rf [DEPTH];
  vector_t vector_rf [DEPTH];

  addr_t wb_addr, s1_addr, s2_addr, v1_addr, v2_addr;
  logic  scalar_wr, vector_wr;

  scalar_t           scalar1, scalar2;
  vector_t           vector1, vector2;
  vector_t           operand1_d, operand2_d;
  vector_lane_mask_t mask_d;
  logic              valid_d;

  logic                 valid_q;
  decoded_instruction_t instruction_q;
  thread_idx_t          thread_idx_q;
  subcycle_t            subcycle_q;
  vector_t              operand1_q, operand2_q;
  vector_lane_mask_t    mask_q;

  assign wb_addr   = {bus.wb_writeback_thread_idx, bus.wb_writeback_reg};
  assign s1_addr   = {bus.ts_thread_idx, bus.ts_instruction.scalar_sel1};
  assign s2_addr   = {bus.ts_thread_idx, bus.ts_instruction.scalar_sel2};
  assign v1_addr   = {bus.ts_thread_idx, bus.ts_instruction.vector_sel1};
  assign v2_addr   = {bus.ts_thread_idx, bus.ts_instruction.vector_sel2};
  assign scalar_wr = bus.wb_writeback_en & ~bus.wb_writeback_is_vector;
  assign vector_wr = bus.wb_writeback_en & bus.wb_writeback_is_vector;

  // Register file writes; rollback never gates these
  always_ff @(posedge clk) begin
    if (scalar_wr) begin
      scalar_rf[wb_addr] <= bus.wb_writeback_value[0];
    end
    if (vector_wr) begin
      for (int lane = 0; lane < LANES; lane++) begin
        if (bus.wb_writeback_mask[lane]) begin
          vector_rf[wb_addr][lane] <= bus.wb_writeback_value[lane];
        end
      end
    end
  end

  // Read the files with same-cycle write bypass (address match implies same thread)
  always_comb begin
    scalar1 = scalar_rf[s1_addr];
    scalar2 = scalar_rf[s2_addr];
    vector1 = vector_rf[v1_addr];
    vector2 = vector_rf[v2_addr];
    if (scalar_wr && wb_addr == s1_addr) scalar1 = bus.wb_writeback_value[0];
    if (scalar_wr && wb_addr == s2_addr) scalar2 = bus.wb_writeback_value[0];
    for (int lane = 0; lane < LANES; lane++) begin
      if (vector_wr && wb_addr == v1_addr && bus.wb_writeback_mask[lane]) begin
        vector1[lane] = bus.wb_writeback_value[lane];
      end
      if (vector_wr && wb_addr == v2_addr && bus.wb_writeback_mask[lane]) begin
        vector2[lane] = bus.wb_writeback_value[lane];
      end
    end
  end

  // Operand, mask and issue-cycle squash selection
  always_comb begin
    operand1_d = bus.ts_instruction.op1_is_vector ? vector1 : {LANES{scalar1}};
    case (bus.ts_instruction.op2_src)
      Op2Scalar2: operand2_d = {LANES{scalar2}};
      Op2Vector2: operand2_d = vector2;
      default:    operand2_d = {LANES{bus.ts_instruction.immediate_value}};
    endcase
    case (bus.ts_instruction.mask_src)
      MaskScalar1: mask_d = scalar1[LANES-1:0];
      MaskScalar2: mask_d = scalar2[LANES-1:0];
      default:     mask_d = '1;
    endcase
    valid_d = bus.ts_instruction_valid &
              ~(bus.wb_rollback_en && bus.wb_rollback_thread_idx == bus.ts_thread_idx);
  end

  // Valid is the only reset state; reset clears it without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload registers, meaningful only while valid
  always_ff @(posedge clk) begin
    instruction_q <= bus.ts_instruction;
    thread_idx_q  <= bus.ts_thread_idx;
    subcycle_q    <= bus.ts_subcycle;
    operand1_q    <= operand1_d;
    operand2_q    <= operand2_d;
    mask_q        <= mask_d;
  end

  // A rollback arriving while the instruction sits here still kills it
  assign bus.of_instruction_valid = valid_q &
      ~(bus.wb_rollback_en && bus.wb_rollback_thread_idx == thread_idx_q);
  assign bus.of_instruction = instruction_q;
  assign bus.of_thread_idx  = thread_idx_q;
  assign bus.of_subcycle    = subcycle_q;
  assign bus.of_operand1    = operand1_q;
  assign bus.of_operand2    = operand2_q;
  assign bus.of_mask_value  = mask_q;

endmodule

// File: tb/tb_regfile_operand_fetch_stage.sv
// Directed bench for regfile_operand_fetch_stage with hand-computed expectations.

module tb_regfile_operand_fetch_stage;
  import regfile_operand_fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  regfile_operand_fetch_stage_if bus ();

  regfile_operand_fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vector_t bcast(input scalar_t v);
    vector_t r;
    for (int i = 0; i < VECTOR_LANES; i++) r[i] = v;
    return r;
  endfunction

  function automatic decoded_instruction_t nop_instr();
    decoded_instruction_t ins;
    ins = '0;
    ins.op2_src = Op2Immediate;
    ins.mask_src = MaskAllOnes;
    return ins;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_scalar(input thread_idx_t tid, input reg_idx_t r, input scalar_t v);
    bus.wb_writeback_en = 1'b1;
    bus.wb_writeback_thread_idx = tid;
    bus.wb_writeback_is_vector = 1'b0;
    bus.wb_writeback_reg = r;
    bus.wb_writeback_value = bcast(v);
    bus.wb_writeback_mask = '0;
    tick();
    bus.wb_writeback_en = 1'b0;
  endtask

  task automatic set_vector_write(input thread_idx_t tid, input reg_idx_t r, input vector_t v,
                                  input vector_lane_mask_t m);
    bus.wb_writeback_en = 1'b1;
    bus.wb_writeback_thread_idx = tid;
    bus.wb_writeback_is_vector = 1'b1;
    bus.wb_writeback_reg = r;
    bus.wb_writeback_value = v;
    bus.wb_writeback_mask = m;
  endtask

  task automatic issue(input decoded_instruction_t ins, input thread_idx_t tid);
    bus.ts_instruction_valid = 1'b1;
    bus.ts_instruction = ins;
    bus.ts_thread_idx = tid;
    tick();
    bus.ts_instruction_valid = 1'b0;
  endtask

  decoded_instruction_t ins;
  vector_t vtmp;
  vector_t exp_v3;

  initial begin
    reset = 1'b1;
    bus.ts_instruction_valid = 1'b0;
    bus.ts_instruction = nop_instr();
    bus.ts_thread_idx = '0;
    bus.ts_subcycle = '0;
    bus.wb_rollback_en = 1'b0;
    bus.wb_rollback_thread_idx = '0;
    bus.wb_writeback_en = 1'b0;
    bus.wb_writeback_thread_idx = '0;
    bus.wb_writeback_is_vector = 1'b0;
    bus.wb_writeback_reg = '0;
    bus.wb_writeback_value = '0;
    bus.wb_writeback_mask = '0;

    #12;
    check_eq("reset_valid", 512'(bus.of_instruction_valid), 512'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Scalar broadcast plus pass-through fields
    wr_scalar(2'd1, 5'd5, 32'h12345678);
    bus.ts_subcycle = 4'd9;
    ins = nop_instr();
    ins.scalar_sel1 = 5'd5;
    issue(ins, 2'd1);
    check_eq("bcast_valid", 512'(bus.of_instruction_valid), 512'(1'b1));
    check_eq("bcast_op1", bus.of_operand1, bcast(32'h12345678));
    check_eq("bcast_thread", 512'(bus.of_thread_idx), 512'(2'd1));
    check_eq("bcast_subcycle", 512'(bus.of_subcycle), 512'(4'd9));
    check_eq("bcast_instr", 512'(bus.of_instruction), 512'(ins));

    // Masked vector write: full write then low-half overwrite
    for (int i = 0; i < VECTOR_LANES; i++) vtmp[i] = 32'(i);
    set_vector_write(2'd0, 5'd3, vtmp, 16'hFFFF);
    tick();
    for (int i = 0; i < VECTOR_LANES; i++) vtmp[i] = 32'h0A0 + 32'(i);
    set_vector_write(2'd0, 5'd3, vtmp, 16'h00FF);
    tick();
    bus.wb_writeback_en = 1'b0;
    for (int i = 0; i < VECTOR_LANES; i++) exp_v3[i] = (i < 8) ? 32'h0A0 + 32'(i) : 32'(i);
    ins = nop_instr();
    ins.op1_is_vector = 1'b1;
    ins.vector_sel1 = 5'd3;
    ins.op2_src = Op2Vector2;
    ins.vector_sel2 = 5'd3;
    issue(ins, 2'd0);
    check_eq("vmask_op1", bus.of_operand1, exp_v3);
    check_eq("vmask_op2", bus.of_operand2, exp_v3);

    // Scalar bypass on the same thread
    wr_scalar(2'd0, 5'd7, 32'h11111111);
    wr_scalar(2'd2, 5'd7, 32'h22222222);
    bus.wb_writeback_en = 1'b1;
    bus.wb_writeback_thread_idx = 2'd0;
    bus.wb_writeback_is_vector = 1'b0;
    bus.wb_writeback_reg = 5'd7;
    bus.wb_writeback_value = bcast(32'hDEADBEEF);
    ins = nop_instr();
    ins.scalar_sel1 = 5'd7;
    issue(ins, 2'd0);
    bus.wb_writeback_en = 1'b0;
    check_eq("bypass_same", bus.of_operand1, bcast(32'hDEADBEEF));

    // Write to thread 0 while thread 2 reads the same index: no bypass
    bus.wb_writeback_en = 1'b1;
    bus.wb_writeback_value = bcast(32'hCAFEF00D);
    issue(ins, 2'd2);
    bus.wb_writeback_en = 1'b0;
    check_eq("bypass_other", bus.of_operand1, bcast(32'h22222222));

    // Partial vector bypass: only enabled lanes come from the write
    set_vector_write(2'd0, 5'd3, bcast(32'h55), 16'h0F00);
    ins = nop_instr();
    ins.op1_is_vector = 1'b1;
    ins.vector_sel1 = 5'd3;
    issue(ins, 2'd0);
    bus.wb_writeback_en = 1'b0;
    for (int i = 8; i < 12; i++) exp_v3[i] = 32'h55;
    check_eq("bypass_vec", bus.of_operand1, exp_v3);

    // Immediate operand with all-ones mask
    ins = nop_instr();
    ins.immediate_value = 32'hFFFFFFF0;
    issue(ins, 2'd0);
    check_eq("imm_op2", bus.of_operand2, bcast(32'hFFFFFFF0));
    check_eq("allones_mask", 512'(bus.of_mask_value), 512'(16'hFFFF));

    // Mask and operand2 from scalars
    wr_scalar(2'd0, 5'd2, 32'h0001A5A5);
    ins = nop_instr();
    ins.scalar_sel1 = 5'd7;
    ins.scalar_sel2 = 5'd2;
    ins.op2_src = Op2Scalar2;
    ins.mask_src = MaskScalar2;
    issue(ins, 2'd0);
    check_eq("mask_s2", 512'(bus.of_mask_value), 512'(16'hA5A5));
    check_eq("op2_s2", bus.of_operand2, bcast(32'h0001A5A5));
    ins.mask_src = MaskScalar1;
    issue(ins, 2'd0);
    check_eq("mask_s1", 512'(bus.of_mask_value), 512'(16'hF00D));

    // Issue-cycle rollback on the issuing thread
    bus.wb_rollback_en = 1'b1;
    bus.wb_rollback_thread_idx = 2'd2;
    issue(nop_instr(), 2'd2);
    bus.wb_rollback_en = 1'b0;
    #1;
    check_eq("rb_same", 512'(bus.of_instruction_valid), 512'(1'b0));

    // Rollback aimed at another thread
    bus.wb_rollback_en = 1'b1;
    bus.wb_rollback_thread_idx = 2'd3;
    issue(nop_instr(), 2'd2);
    bus.wb_rollback_en = 1'b0;
    #1;
    check_eq("rb_other", 512'(bus.of_instruction_valid), 512'(1'b1));

    // Output-cycle rollback, combinational
    issue(nop_instr(), 2'd2);
    check_eq("rb_out_pre", 512'(bus.of_instruction_valid), 512'(1'b1));
    bus.wb_rollback_en = 1'b1;
    bus.wb_rollback_thread_idx = 2'd2;
    #1;
    check_eq("rb_out_same", 512'(bus.of_instruction_valid), 512'(1'b0));
    bus.wb_rollback_thread_idx = 2'd3;
    #1;
    check_eq("rb_out_other", 512'(bus.of_instruction_valid), 512'(1'b1));
    bus.wb_rollback_en = 1'b0;

    // Register write during rollback of the same thread still lands
    bus.wb_rollback_en = 1'b1;
    bus.wb_rollback_thread_idx = 2'd2;
    wr_scalar(2'd2, 5'd9, 32'h00009999);
    bus.wb_rollback_en = 1'b0;
    ins = nop_instr();
    ins.scalar_sel1 = 5'd9;
    issue(ins, 2'd2);
    check_eq("rb_write", bus.of_operand1, bcast(32'h00009999));

    // Back-to-back issue alternating threads
    ins = nop_instr();
    ins.scalar_sel1 = 5'd5;
    bus.ts_instruction_valid = 1'b1;
    bus.ts_instruction = ins;
    bus.ts_thread_idx = 2'd1;
    tick();
    check_eq("b2b_first", bus.of_operand1, bcast(32'h12345678));
    ins.scalar_sel1 = 5'd2;
    bus.ts_instruction = ins;
    bus.ts_thread_idx = 2'd0;
    tick();
    bus.ts_instruction_valid = 1'b0;
    check_eq("b2b_second", bus.of_operand1, bcast(32'h0001A5A5));
    check_eq("b2b_valid", 512'(bus.of_instruction_valid), 512'(1'b1));

    // Async reset mid-stream, storage survives
    ins = nop_instr();
    ins.scalar_sel1 = 5'd5;
    issue(ins, 2'd1);
    check_eq("pre_reset_valid", 512'(bus.of_instruction_valid), 512'(1'b1));
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset_valid", 512'(bus.of_instruction_valid), 512'(1'b0));
    #1;
    reset = 1'b0;
    tick();
    check_eq("post_reset_idle", 512'(bus.of_instruction_valid), 512'(1'b0));
    issue(ins, 2'd1);
    check_eq("post_reset_scalar", bus.of_operand1, bcast(32'h12345678));
    ins = nop_instr();
    ins.op1_is_vector = 1'b1;
    ins.vector_sel1 = 5'd3;
    issue(ins, 2'd0);
    check_eq("post_reset_vector", bus.of_operand1, exp_v3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
